// File: rtl/exec_unit_m.sv
// Integer execution unit: 1-cycle RV32I arith/branch/jump/LUI/AUIPC, multi-cycle RV32M MUL/DIV/REM.
// One op in flight; the CDB result is a one-rdy-cycle pulse; rollback kills in-flight work.
module exec_unit_m #(
    parameter int XLEN       = 32,
    parameter int ROB_POS_W  = 4,
    parameter int MUL_CYCLES = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 rollback,
    input  logic                 issue_valid,
    output logic                 issue_ready,
    input  logic [6:0]           opcode,
    input  logic [2:0]           funct3,
    input  logic                 funct7_sub,
    input  logic                 funct7_m,
    input  logic [XLEN-1:0]      val1,
    input  logic [XLEN-1:0]      val2,
    input  logic [XLEN-1:0]      imm,
    input  logic [XLEN-1:0]      pc,
    input  logic [ROB_POS_W-1:0] rob_pos,
    output logic                 result,
    output logic [ROB_POS_W-1:0] result_rob_pos,
    output logic [XLEN-1:0]      result_val,
    output logic                 result_jump,
    output logic [XLEN-1:0]      result_pc
);
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BR     = 7'b1100011;
    localparam logic [6:0] OP_ARITH  = 7'b0110011;
    localparam int SH_W    = $clog2(XLEN);
    localparam int CNT_MAX = (XLEN > MUL_CYCLES) ? XLEN : MUL_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

    state_t               state_q, state_d;
    logic [XLEN-1:0]      a1_q, a1_d, a2_q, a2_d, rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
    logic [2:0]           f3_q, f3_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ROB_POS_W-1:0] rob_q, rob_d, orob_q, orob_d;
    logic                 res_q, res_d, jmp_q, jmp_d;
    logic [XLEN-1:0]      val_q, val_d, npc_q, npc_d;

    logic            accept, is_m, taken, in_sgn;
    logic [XLEN-1:0] op2, alu, pc4, pcimm, ex_val, ex_pc, mag1, mag2;
    logic            ex_jmp;
    logic [SH_W-1:0] shamt;

    assign issue_ready = (state_q == S_IDLE);
    assign accept      = issue_valid & issue_ready & rdy & ~rollback;
    assign is_m        = (opcode == OP_ARITH) & funct7_m;

    always_comb begin
        op2   = (opcode == OP_ARITH) ? val2 : imm;
        shamt = op2[SH_W-1:0];
        case (funct3)
            3'd0:    alu = ((opcode == OP_ARITH) && funct7_sub) ? val1 - op2 : val1 + op2;
            3'd1:    alu = val1 << shamt;
            3'd2:    alu = {{(XLEN-1){1'b0}}, ($signed(val1) < $signed(op2))};
            3'd3:    alu = {{(XLEN-1){1'b0}}, (val1 < op2)};
            3'd4:    alu = val1 ^ op2;
            3'd5:    alu = funct7_sub ? XLEN'($signed(val1) >>> shamt) : val1 >> shamt;
            3'd6:    alu = val1 | op2;
            default: alu = val1 & op2;
        endcase
        case (funct3)
            3'd0:    taken = (val1 == val2);
            3'd1:    taken = (val1 != val2);
            3'd4:    taken = ($signed(val1) < $signed(val2));
            3'd5:    taken = ($signed(val1) >= $signed(val2));
            3'd6:    taken = (val1 < val2);
            3'd7:    taken = (val1 >= val2);
            default: taken = 1'b0;
        endcase
        pc4    = pc + XLEN'(4);
        pcimm  = pc + imm;
        ex_val = alu;
        ex_jmp = 1'b0;
        ex_pc  = pc4;
        case (opcode)
            OP_LUI:   ex_val = imm;
            OP_AUIPC: ex_val = pcimm;
            OP_JAL:   begin ex_val = pc4; ex_pc = pcimm; ex_jmp = 1'b1; end
            OP_JALR:  begin ex_val = pc4; ex_pc = (val1 + imm) & ~XLEN'(1); ex_jmp = 1'b1; end
            OP_BR:    begin ex_val = '0; ex_jmp = taken; ex_pc = taken ? pcimm : pc4; end
            default:  ;
        endcase
        // Divider works on magnitudes; signs are restored from the latched operands at the end.
        in_sgn = ~funct3[0];
        mag1   = (in_sgn & val1[XLEN-1]) ? -val1 : val1;
        mag2   = (in_sgn & val2[XLEN-1]) ? -val2 : val2;
    end

    logic [2*XLEN-1:0] m1, m2, prod;
    logic [XLEN-1:0]   mul_res, div_res, spec_res, q_fix, r_fix;
    logic [XLEN:0]     rem_sh, trial;
    logic              d_sgn, s1, s2, div_zero, div_ovf;

    always_comb begin
        m1       = {{XLEN{a1_q[XLEN-1] & (f3_q != 3'd3)}}, a1_q};
        m2       = {{XLEN{a2_q[XLEN-1] & (f3_q == 3'd1)}}, a2_q};
        prod     = m1 * m2;
        mul_res  = (f3_q[1:0] == 2'd0) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        d_sgn    = ~f3_q[0];
        s1       = d_sgn & a1_q[XLEN-1];
        s2       = d_sgn & a2_q[XLEN-1];
        div_zero = (a2_q == '0);
        div_ovf  = d_sgn && (a1_q == {1'b1, {(XLEN-1){1'b0}}}) && (a2_q == '1);
        rem_sh   = {rem_q, quo_q[XLEN-1]};
        trial    = rem_sh - {1'b0, dvs_q};
        q_fix    = (s1 ^ s2) ? -quo_q : quo_q;
        r_fix    = s1 ? -rem_q : rem_q;
        div_res  = f3_q[1] ? r_fix : q_fix;
        spec_res = div_zero ? (f3_q[1] ? a1_q : '1) : (f3_q[1] ? '0 : a1_q);
    end

    always_comb begin
        state_d = state_q;
        a1_d = a1_q; a2_d = a2_q; rem_d = rem_q; quo_d = quo_q; dvs_d = dvs_q;
        f3_d = f3_q; cnt_d = cnt_q; rob_d = rob_q; orob_d = orob_q;
        res_d = res_q; jmp_d = jmp_q; val_d = val_q; npc_d = npc_q;
        if (rollback) begin
            state_d = S_IDLE;
            res_d = 1'b0; jmp_d = 1'b0; val_d = '0; npc_d = '0; orob_d = '0;
        end else if (rdy) begin
            res_d = 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept && is_m) begin
                        state_d = funct3[2] ? S_DIV : S_MUL;
                        a1_d = val1; a2_d = val2; f3_d = funct3; rob_d = rob_pos;
                        cnt_d = '0; rem_d = '0; quo_d = mag1; dvs_d = mag2;
                    end else if (accept) begin
                        res_d = 1'b1; jmp_d = ex_jmp; val_d = ex_val; npc_d = ex_pc; orob_d = rob_pos;
                    end
                end
                S_MUL: begin
                    if (cnt_q == CNT_W'(MUL_CYCLES - 1)) begin
                        state_d = S_IDLE;
                        res_d = 1'b1; jmp_d = 1'b0; val_d = mul_res; npc_d = '0; orob_d = rob_q;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_DIV: begin
                    if ((cnt_q == '0) && (div_zero || div_ovf)) begin
                        state_d = S_IDLE;
                        res_d = 1'b1; jmp_d = 1'b0; val_d = spec_res; npc_d = '0; orob_d = rob_q;
                    end else if (cnt_q == CNT_W'(XLEN)) begin
                        state_d = S_IDLE;
                        res_d = 1'b1; jmp_d = 1'b0; val_d = div_res; npc_d = '0; orob_d = rob_q;
                    end else begin
                        // Restoring step: keep the trial remainder only when it did not borrow.
                        rem_d = trial[XLEN] ? rem_sh[XLEN-1:0] : trial[XLEN-1:0];
                        quo_d = {quo_q[XLEN-2:0], ~trial[XLEN]};
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a1_q <= '0; a2_q <= '0; rem_q <= '0; quo_q <= '0; dvs_q <= '0;
            f3_q <= '0; cnt_q <= '0; rob_q <= '0; orob_q <= '0;
            res_q <= 1'b0; jmp_q <= 1'b0; val_q <= '0; npc_q <= '0;
        end else begin
            state_q <= state_d;
            a1_q <= a1_d; a2_q <= a2_d; rem_q <= rem_d; quo_q <= quo_d; dvs_q <= dvs_d;
            f3_q <= f3_d; cnt_q <= cnt_d; rob_q <= rob_d; orob_q <= orob_d;
            res_q <= res_d; jmp_q <= jmp_d; val_q <= val_d; npc_q <= npc_d;
        end
    end

    assign result         = res_q;
    assign result_rob_pos = orob_q;
    assign result_val     = val_q;
    assign result_jump    = jmp_q;
    assign result_pc      = npc_q;
endmodule

// File: tb/tb_exec_unit_m.sv
// Bench for exec_unit_m: directed literal cases plus randomized traffic against a latency/value model.
`timescale 1ns/1ps
module tb_exec_unit_m;
    localparam int XLEN = 32;
    localparam int RW   = 4;
    localparam int MULC = 3;
    localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111, OP_BR = 7'b1100011;
    localparam logic [6:0] OP_ARITHI = 7'b0010011, OP_ARITH = 7'b0110011;

    logic clk, rst, rdy, rollback, issue_valid, issue_ready;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic funct7_sub, funct7_m;
    logic [31:0] val1, val2, imm, pc;
    logic [RW-1:0] rob_pos, result_rob_pos;
    logic result, result_jump;
    logic [31:0] result_val, result_pc;

    int n_cmp = 0;
    int n_err = 0;

    exec_unit_m #(.XLEN(XLEN), .ROB_POS_W(RW), .MUL_CYCLES(MULC)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .opcode(opcode), .funct3(funct3), .funct7_sub(funct7_sub), .funct7_m(funct7_m),
        .val1(val1), .val2(val2), .imm(imm), .pc(pc), .rob_pos(rob_pos),
        .result(result), .result_rob_pos(result_rob_pos), .result_val(result_val),
        .result_jump(result_jump), .result_pc(result_pc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference semantics: what the op produces and how many rdy edges after acceptance it takes.
    function automatic void ref_op(input logic [6:0] opc, input logic [2:0] f3, input logic sub,
                                   input logic m, input logic [31:0] v1, input logic [31:0] v2,
                                   input logic [31:0] im, input logic [31:0] p,
                                   output logic [31:0] val, output logic jmp, output logic [31:0] npc,
                                   output int lat, output bit ctl, output bit chkval);
        logic [31:0] b, q, r;
        logic [63:0] p64;
        longint x, y;
        int sa, sb;
        bit tk;
        val = 0; jmp = 0; npc = p + 4; lat = 0; ctl = 0; chkval = 1;
        if (opc == OP_LUI) val = im;
        else if (opc == OP_AUIPC) val = p + im;
        else if (opc == OP_JAL) begin val = p + 4; npc = p + im; jmp = 1; ctl = 1; end
        else if (opc == OP_JALR) begin val = p + 4; npc = (v1 + im) & 32'hFFFF_FFFE; jmp = 1; ctl = 1; end
        else if (opc == OP_BR) begin
            case (f3)
                3'd0: tk = (v1 == v2);
                3'd1: tk = (v1 != v2);
                3'd4: tk = ($signed(v1) < $signed(v2));
                3'd5: tk = ($signed(v1) >= $signed(v2));
                3'd6: tk = (v1 < v2);
                default: tk = (v1 >= v2);
            endcase
            jmp = tk; npc = tk ? p + im : p + 4; ctl = 1; chkval = 0;
        end else if (opc == OP_ARITH && m) begin
            if (f3 < 4) begin
                x = (f3 == 3) ? longint'({32'b0, v1}) : longint'($signed(v1));
                y = (f3 == 1) ? longint'($signed(v2)) : longint'({32'b0, v2});
                p64 = 64'(x * y);
                val = (f3 == 0) ? p64[31:0] : p64[63:32];
                lat = MULC;
            end else begin
                lat = XLEN + 1;
                if (v2 == 0) begin q = 32'hFFFF_FFFF; r = v1; lat = 1; end
                else if (!f3[0] && v1 == 32'h8000_0000 && v2 == 32'hFFFF_FFFF) begin q = v1; r = 0; lat = 1; end
                else if (!f3[0]) begin sa = $signed(v1); sb = $signed(v2); q = sa / sb; r = sa % sb; end
                else begin q = v1 / v2; r = v1 % v2; end
                val = f3[1] ? r : q;
            end
        end else begin
            b = (opc == OP_ARITH) ? v2 : im;
            case (f3)
                3'd0: val = (opc == OP_ARITH && sub) ? v1 - b : v1 + b;
                3'd1: val = v1 << b[4:0];
                3'd2: val = ($signed(v1) < $signed(b)) ? 1 : 0;
                3'd3: val = (v1 < b) ? 1 : 0;
                3'd4: val = v1 ^ b;
                3'd5: val = sub ? 32'($signed(v1) >>> b[4:0]) : v1 >> b[4:0];
                3'd6: val = v1 | b;
                default: val = v1 & b;
            endcase
        end
    endfunction

    // Model state: expected output fields and a countdown for the op in flight.
    bit m_busy = 0, m_res = 0, m_zero = 1, m_ctl = 0, m_chkval = 0, p_ctl = 0, p_chkval = 0;
    int m_left = 0, lat;
    logic [31:0] m_val = 0, m_pc = 0, p_val = 0, p_pc = 0;
    logic m_jmp = 0, p_jmp = 0;
    logic [RW-1:0] m_rob = 0, p_rob = 0;

    always @(posedge clk or posedge rst) begin
        if (rst || rollback) begin
            m_busy = 0; m_res = 0; m_zero = 1;
        end else if (rdy) begin
            m_res = 0;
            if (m_busy) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 0; m_res = 1; m_zero = 0;
                    m_val = p_val; m_jmp = p_jmp; m_pc = p_pc; m_rob = p_rob; m_ctl = p_ctl; m_chkval = p_chkval;
                end
            end else if (issue_valid) begin
                ref_op(opcode, funct3, funct7_sub, funct7_m, val1, val2, imm, pc,
                       p_val, p_jmp, p_pc, lat, p_ctl, p_chkval);
                p_rob = rob_pos;
                if (lat == 0) begin
                    m_res = 1; m_zero = 0;
                    m_val = p_val; m_jmp = p_jmp; m_pc = p_pc; m_rob = p_rob; m_ctl = p_ctl; m_chkval = p_chkval;
                end else begin
                    m_busy = 1; m_left = lat;
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        chk("issue_ready", {31'b0, issue_ready}, {31'b0, !m_busy});
        chk("result", {31'b0, result}, {31'b0, m_res});
        if (m_res) begin
            chk("result_rob_pos", 32'(result_rob_pos), 32'(m_rob));
            chk("result_jump", {31'b0, result_jump}, {31'b0, m_jmp});
            if (m_chkval) chk("result_val", result_val, m_val);
            if (m_ctl) chk("result_pc", result_pc, m_pc);
        end else if (m_zero) begin
            chk("cleared val", result_val, 0);
            chk("cleared pc", result_pc, 0);
            chk("cleared jump/rob", {27'b0, result_jump, result_rob_pos}, 0);
        end
    end

    task automatic drive(input logic [6:0] opc, input logic [2:0] f3, input logic sub, input logic m,
                         input logic [31:0] v1, input logic [31:0] v2, input logic [31:0] im,
                         input logic [31:0] p);
        @(negedge clk);
        issue_valid = 1; opcode = opc; funct3 = f3; funct7_sub = sub; funct7_m = m;
        val1 = v1; val2 = v2; imm = im; pc = p; rob_pos = RW'($urandom_range(0, 15));
        @(posedge clk); #1;
        issue_valid = 0;
    endtask

    // Issues one op, then counts edges until the result pulse (bounded).
    task automatic run_op(input string name, input logic [6:0] opc, input logic [2:0] f3,
                          input logic sub, input logic m, input logic [31:0] v1, input logic [31:0] v2,
                          input logic [31:0] im, input logic [31:0] p, input int exp_lat,
                          input logic [31:0] exp_val);
        int n = 0;
        drive(opc, f3, sub, m, v1, v2, im, p);
        if (exp_lat > 0) chk({name, " busy"}, {31'b0, issue_ready}, 0);
        while (!result && n < 40) begin @(posedge clk); #1; n++; end
        chk({name, " latency"}, n, exp_lat);
        chk({name, " val"}, result_val, exp_val);
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    logic [6:0] ops [7] = '{OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BR, OP_ARITHI, OP_ARITH};

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1; rdy = 1; rollback = 0; issue_valid = 0; opcode = 0; funct3 = 0;
        funct7_sub = 0; funct7_m = 0; val1 = 0; val2 = 0; imm = 0; pc = 0; rob_pos = 0;
        #13;
        chk("reset result", {31'b0, result}, 0);
        chk("reset val", result_val, 0);
        chk("reset pc", result_pc, 0);
        chk("reset ready", {31'b0, issue_ready}, 1);
        @(negedge clk); rst = 0;

        run_op("ADD", OP_ARITH, 3'd0, 0, 0, 5, 7, 0, 0, 0, 12);
        chk("ADD jump", {31'b0, result_jump}, 0);
        @(posedge clk); #1;
        chk("ADD pulse end", {31'b0, result}, 0);
        run_op("SUB", OP_ARITH, 3'd0, 1, 0, 5, 7, 0, 0, 0, 32'hFFFF_FFFE);
        run_op("SRA", OP_ARITH, 3'd5, 1, 0, 32'h8000_0000, 4, 0, 0, 0, 32'hF800_0000);
        run_op("BGE", OP_BR, 3'd5, 0, 0, 3, 3, 8, 32'h100, 0, 0);
        chk("BGE jump", {31'b0, result_jump}, 1);
        chk("BGE pc", result_pc, 32'h108);
        run_op("BNE", OP_BR, 3'd1, 0, 0, 3, 3, 8, 32'h100, 0, 0);
        chk("BNE jump", {31'b0, result_jump}, 0);
        chk("BNE pc", result_pc, 32'h104);
        run_op("JALR", OP_JALR, 3'd0, 0, 0, 32'h1001, 0, 4, 32'h200, 0, 32'h204);
        chk("JALR pc", result_pc, 32'h1004);
        run_op("MULHU", OP_ARITH, 3'd3, 0, 1, 32'hFFFF_FFFF, 2, 0, 0, 3, 1);
        run_op("MUL", OP_ARITH, 3'd0, 0, 1, 32'hFFFF_FFFF, 2, 0, 0, 3, 32'hFFFF_FFFE);
        chk("MUL jump", {31'b0, result_jump}, 0);
        run_op("DIV", OP_ARITH, 3'd4, 0, 1, 32'hFFFF_FFF9, 2, 0, 0, 33, 32'hFFFF_FFFD);
        run_op("REM", OP_ARITH, 3'd6, 0, 1, 32'hFFFF_FFF9, 2, 0, 0, 33, 32'hFFFF_FFFF);
        run_op("DIVU0", OP_ARITH, 3'd5, 0, 1, 9, 0, 0, 0, 1, 32'hFFFF_FFFF);
        run_op("DIVOVF", OP_ARITH, 3'd4, 0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 1, 32'h8000_0000);
        run_op("REMOVF", OP_ARITH, 3'd6, 0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 1, 0);

        // Rollback ten edges into a divide.
        drive(OP_ARITH, 3'd4, 0, 1, 100, 7, 0, 0);
        repeat (9) @(posedge clk);
        @(negedge clk); rollback = 1;
        @(posedge clk); #1;
        chk("rollback result", {31'b0, result}, 0);
        chk("rollback ready", {31'b0, issue_ready}, 1);
        chk("rollback val", result_val, 0);
        @(negedge clk); rollback = 0;
        n = 0;
        repeat (40) begin @(posedge clk); #1; if (result) n++; end
        chk("rollback pulses", n, 0);

        // Five stalled cycles in the middle of a multiply.
        drive(OP_ARITH, 3'd0, 0, 1, 32'h1234_5678, 32'h10, 0, 0);
        @(posedge clk); #1; rdy = 0;
        repeat (5) @(posedge clk);
        #1; rdy = 1;
        n = 6;
        chk("stall no early result", {31'b0, result}, 0);
        while (!result && n < 40) begin @(posedge clk); #1; n++; end
        chk("stall latency", n, 8);
        chk("stall val", result_val, 32'h2345_6780);

        // Async reset in the middle of a divide.
        drive(OP_ARITH, 3'd4, 0, 1, 1000, 3, 0, 0);
        repeat (5) @(posedge clk);
        #3; rst = 1; #1;
        chk("arst result", {31'b0, result}, 0);
        chk("arst val", result_val, 0);
        chk("arst ready", {31'b0, issue_ready}, 1);
        @(negedge clk); rst = 0;
        run_op("post-reset ADDI", OP_ARITHI, 3'd0, 1, 0, 32'hFFFF_FFFF, 0, 2, 0, 0, 1);

        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            rdy = ($urandom_range(0, 99) < 85);
            rollback = ($urandom_range(0, 299) == 0);
            issue_valid = ($urandom_range(0, 99) < 60);
            opcode = ops[$urandom_range(0, 6)];
            funct3 = 3'($urandom_range(0, 7));
            if (opcode == OP_BR && (funct3 == 3'd2 || funct3 == 3'd3)) funct3 = 3'd0;
            funct7_sub = 1'($urandom_range(0, 1));
            funct7_m = 1'($urandom_range(0, 1));
            val1 = rnd_val(); val2 = rnd_val(); imm = rnd_val(); pc = $urandom;
            rob_pos = RW'($urandom_range(0, 15));
        end
        @(negedge clk);
        rdy = 1; rollback = 0; issue_valid = 0;
        repeat (40) @(posedge clk);
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
